// File: rtl/accum_step_alu.sv
// accum_step_alu: step-driven accumulator with ADD/SUB/LOAD/CLEAR modes.
// A button-level step request is synchronised onto clk and edge-detected;
// each synchronised rising edge executes exactly one operation.
// acc, carry, overflow, sticky_ovf and op_cnt are registered.
// zero and neg are decoded combinationally from acc.
module accum_step_alu #(
   parameter int WIDTH       = 8,
   parameter int SATURATE    = 0,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic             cin,
   output logic [WIDTH-1:0] acc,
   output logic             carry,
   output logic             overflow,
   output logic             sticky_ovf,
   output logic             zero,
   output logic             neg,
   output logic [CNT_W-1:0] op_cnt
);

   localparam int MSB = WIDTH - 1;
   localparam bit SAT_EN = (SATURATE != 0);

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   fire;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;
   logic             add_ovf;
   logic             sub_ovf;
   logic [WIDTH-1:0] sat_val;
   logic [CNT_W-1:0] cnt_inc;

   // Step synchroniser chain plus the edge flop remembering the last synced level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], step};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // One-cycle pulse on each synchronised rising edge of step.
   assign fire = sync_q[SYNC_STAGES-1] & ~prev_q;

   // Both arithmetic results are one bit wider so the top bit is carry / borrow.
   // For SUB the wide difference is negative exactly when acc < a + cin.
   assign sum_w  = {1'b0, acc_q} + {1'b0, a} + {{WIDTH{1'b0}}, cin};
   assign diff_w = {1'b0, acc_q} - {1'b0, a} - {{WIDTH{1'b0}}, cin};

   assign add_ovf = (acc_q[MSB] == a[MSB]) & (sum_w[MSB]  != acc_q[MSB]);
   assign sub_ovf = (acc_q[MSB] != a[MSB]) & (diff_w[MSB] != acc_q[MSB]);

   // On overflow the true result lies beyond the rail on the side of the old sign.
   assign sat_val = acc_q[MSB] ? SAT_MIN : SAT_MAX;

   // Operation counter sticks at all-ones instead of wrapping.
   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   // Next-state datapath: everything holds unless a step edge fires.
   always_comb begin
      acc_d    = acc_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (fire) begin
         case (op)
            OP_ADD: begin
               carry_d  = sum_w[WIDTH];
               ovf_d    = add_ovf;
               sticky_d = sticky_q | add_ovf;
               acc_d    = (SAT_EN && add_ovf) ? sat_val : sum_w[WIDTH-1:0];
               cnt_d    = cnt_inc;
            end
            OP_SUB: begin
               carry_d  = diff_w[WIDTH];
               ovf_d    = sub_ovf;
               sticky_d = sticky_q | sub_ovf;
               acc_d    = (SAT_EN && sub_ovf) ? sat_val : diff_w[WIDTH-1:0];
               cnt_d    = cnt_inc;
            end
            OP_LOAD: begin
               acc_d   = a;
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               cnt_d   = cnt_inc;
            end
            OP_CLEAR: begin
               acc_d    = '0;
               carry_d  = 1'b0;
               ovf_d    = 1'b0;
               sticky_d = 1'b0;
               cnt_d    = '0;
            end
            default: begin
               acc_d = acc_q;
            end
         endcase
      end
   end

   // Architectural state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         acc_q    <= acc_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign acc        = acc_q;
   assign carry      = carry_q;
   assign overflow   = ovf_q;
   assign sticky_ovf = sticky_q;
   assign op_cnt     = cnt_q;
   assign zero       = (acc_q == '0);
   assign neg        = acc_q[MSB];

endmodule
